adder_reg_arbiter: RTL and testbench

Round-robin controller that shares one registered adder (BITWIDTH-bit operands, BITWIDTH+1-bit registered sum, with enable and clear) between NUM_REQ requesters. It accepts one operand pair per transaction using a valid/ready handshake and drives the adder's enable, clear and operand inputs. It captures the registered sum and returns it on a response valid/ready channel, tagged with the requester index. The block sits between requester logic and a single adder_reg instance.

---
 rtl/adder_reg_arbiter.sv | 133 +++++++++++++
 tb/tb_adder_reg_arbiter.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_reg_arbiter.sv
// Round-robin front end that time-shares one registered adder between NUM_REQ requesters.
// Each accepted operand pair returns its registered sum on a response channel, tagged with the requester index.
module adder_reg_arbiter #(
    parameter int unsigned BITWIDTH  = 32,
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned IDX_W     = $clog2(NUM_REQ),
    parameter int unsigned CLR_AFTER = 1
) (
    input  logic                        iClk,
    input  logic                        iRst,
    input  logic [NUM_REQ-1:0]          iReqValid,
    output logic [NUM_REQ-1:0]          oReqReady,
    input  logic [NUM_REQ*BITWIDTH-1:0] iReqData0,
    input  logic [NUM_REQ*BITWIDTH-1:0] iReqData1,
    output logic                        oRspValid,
    input  logic                        iRspReady,
    output logic [BITWIDTH:0]           oRspData,
    output logic [IDX_W-1:0]            oRspId,
    output logic                        oAddEn,
    output logic                        oAddClr,
    output logic [BITWIDTH-1:0]         oAddData0,
    output logic [BITWIDTH-1:0]         oAddData1,
    input  logic [BITWIDTH:0]           iAddSum
);

    localparam int unsigned SUM_W = BITWIDTH + 1;

    typedef enum logic [1:0] {
        ST_CLR,
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [IDX_W-1:0]    ptr;
    logic [IDX_W-1:0]    ptr_inc;
    logic [IDX_W-1:0]    cand;
    logic [IDX_W-1:0]    gnt_idx;
    logic                gnt_vld;
    logic [SUM_W-1:0]    rsp_data;
    logic [IDX_W-1:0]    rsp_id;
    logic [BITWIDTH-1:0] opa [NUM_REQ];
    logic [BITWIDTH-1:0] opb [NUM_REQ];

    for (genvar k = 0; k < NUM_REQ; k++) begin : g_unpack
        assign opa[k] = iReqData0[k*BITWIDTH +: BITWIDTH];
        assign opb[k] = iReqData1[k*BITWIDTH +: BITWIDTH];
    end

    // First valid requester at or after ptr, wrapping modulo NUM_REQ.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cand = IDX_W'((32'(ptr) + i) % NUM_REQ);
            if (!gnt_vld && iReqValid[cand]) begin
                gnt_vld = 1'b1;
                gnt_idx = cand;
            end
        end
    end

    assign ptr_inc = IDX_W'((32'(gnt_idx) + 32'd1) % NUM_REQ);

    // Next state and handshake/adder drive; everything idles low except clear during reset.
    always_comb begin
        state_nxt = state;
        oReqReady = '0;
        oAddEn    = 1'b0;
        oAddClr   = 1'b0;
        oAddData0 = '0;
        oAddData1 = '0;
        oRspValid = 1'b0;
        if (iRst) begin
            oAddClr = 1'b1;
        end else begin
            case (state)
                ST_CLR: begin
                    oAddClr   = 1'b1;
                    state_nxt = ST_IDLE;
                end
                ST_IDLE: begin
                    if (gnt_vld) begin
                        oReqReady = NUM_REQ'(1) << gnt_idx;
                        oAddEn    = 1'b1;
                        oAddData0 = opa[gnt_idx];
                        oAddData1 = opb[gnt_idx];
                        state_nxt = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    state_nxt = ST_RESP;
                end
                ST_RESP: begin
                    oRspValid = 1'b1;
                    if (iRspReady) begin
                        state_nxt = (CLR_AFTER != 0) ? ST_CLR : ST_IDLE;
                    end
                end
                default: begin
                    state_nxt = ST_CLR;
                end
            endcase
        end
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            state    <= ST_CLR;
            ptr      <= '0;
            rsp_data <= '0;
            rsp_id   <= '0;
        end else begin
            state <= state_nxt;
            if (state == ST_IDLE && gnt_vld) begin
                rsp_id <= gnt_idx;
                ptr    <= ptr_inc;
            end
            // Adder output is valid one cycle after the enable pulse.
            if (state == ST_WAIT) begin
                rsp_data <= iAddSum;
            end
        end
    end

    // Response fields read as zero while reset is asserted, even before the first reset edge.
    assign oRspData = iRst ? '0 : rsp_data;
    assign oRspId   = iRst ? '0 : rsp_id;

endmodule

// File: tb/tb_adder_reg_arbiter.sv
// Bench for adder_reg_arbiter: models the shared adder, checks every cycle against a
// transaction-level reference, and pins the reference with directed literal checks.
module tb_adder_reg_arbiter;

    localparam int unsigned BW = 32;
    localparam int unsigned N  = 4;
    localparam int unsigned IW = 2;
    localparam int unsigned CA = 1;

    logic            clk;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N*BW-1:0] req_d0;
    logic [N*BW-1:0] req_d1;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [BW:0]     rsp_data;
    logic [IW-1:0]   rsp_id;
    logic            add_en;
    logic            add_clr;
    logic [BW-1:0]   add_a;
    logic [BW-1:0]   add_b;
    logic [BW:0]     add_sum;

    logic [BW-1:0] opa [N];
    logic [BW-1:0] opb [N];

    for (genvar k = 0; k < N; k++) begin : g_pack
        assign req_d0[k*BW +: BW] = opa[k];
        assign req_d1[k*BW +: BW] = opb[k];
    end

    adder_reg_arbiter #(
        .BITWIDTH (BW),
        .NUM_REQ  (N),
        .IDX_W    (IW),
        .CLR_AFTER(CA)
    ) dut (
        .iClk     (clk),
        .iRst     (rst),
        .iReqValid(req_valid),
        .oReqReady(req_ready),
        .iReqData0(req_d0),
        .iReqData1(req_d1),
        .oRspValid(rsp_valid),
        .iRspReady(rsp_ready),
        .oRspData (rsp_data),
        .oRspId   (rsp_id),
        .oAddEn   (add_en),
        .oAddClr  (add_clr),
        .oAddData0(add_a),
        .oAddData1(add_b),
        .iAddSum  (add_sum)
    );

    // The shared registered adder the block talks to.
    always_ff @(posedge clk) begin
        if (add_clr) add_sum <= '0;
        else if (add_en) add_sum <= {1'b0, add_a} + {1'b0, add_b};
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Reference: pending clear cycle, cycles to response, outstanding response, pointer.
    bit          m_clr;
    bit          m_wait;
    bit          m_rsp;
    int          m_ptr;
    logic [BW:0] m_sum;
    int          m_id;

    logic [N-1:0]  s_ready;
    logic          s_en, s_clr, s_rv;
    logic [BW:0]   s_rd;
    logic [IW-1:0] s_rid;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [BW-1:0] rand_op();
        case ($urandom_range(0, 3))
            0:       return '1;
            1:       return 32'd1;
            default: return $urandom();
        endcase
    endfunction

    // Check the current cycle against the reference, then advance it across the next edge.
    task automatic step();
        logic [N-1:0]  e_ready;
        logic          e_en, e_clr, e_rv;
        logic [BW-1:0] e_a, e_b;
        bit            found;
        int            g;
        e_ready = '0; e_en = 0; e_clr = 0; e_rv = 0; e_a = '0; e_b = '0;
        found = 0; g = 0;
        #1;
        if (rst) begin
            e_clr = 1;
        end else if (m_clr) begin
            e_clr = 1;
        end else if (m_rsp) begin
            e_rv = 1;
        end else if (!m_wait) begin
            for (int off = 0; off < N; off++) begin
                int k;
                k = (m_ptr + off) % N;
                if (!found && req_valid[IW'(k)]) begin
                    found = 1;
                    g = k;
                end
            end
            if (found) begin
                e_ready = N'(1) << g;
                e_en    = 1;
                e_a     = opa[IW'(g)];
                e_b     = opb[IW'(g)];
            end
        end
        s_ready = req_ready; s_en = add_en; s_clr = add_clr;
        s_rv = rsp_valid; s_rd = rsp_data; s_rid = rsp_id;
        chk("ready", s_ready, e_ready);
        chk("add_en", s_en, e_en);
        chk("add_clr", s_clr, e_clr);
        chk("add_a", add_a, e_a);
        chk("add_b", add_b, e_b);
        chk("rsp_valid", s_rv, e_rv);
        if (rst) begin
            chk("rst_rsp_data", s_rd, 0);
            chk("rst_rsp_id", s_rid, 0);
        end else if (e_rv) begin
            chk("rsp_data", s_rd, m_sum);
            chk("rsp_id", s_rid, m_id);
        end
        if (rst) begin
            m_clr = 1; m_wait = 0; m_rsp = 0; m_ptr = 0;
        end else if (m_clr) begin
            m_clr = 0;
        end else if (m_rsp) begin
            if (rsp_ready) begin
                m_rsp = 0;
                m_clr = (CA != 0);
            end
        end else if (m_wait) begin
            m_wait = 0;
            m_rsp  = 1;
        end else if (found) begin
            m_wait = 1;
            m_id   = g;
            m_sum  = {1'b0, e_a} + {1'b0, e_b};
            m_ptr  = (g + 1) % N;
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic wait_grant(output int g);
        bit got;
        got = 0;
        g = -1;
        for (int i = 0; i < 30 && !got; i++) begin
            step();
            if (s_ready != '0) begin
                got = 1;
                for (int k = 0; k < N; k++) if (s_ready[IW'(k)]) g = k;
            end
        end
        if (!got) begin
            n_tests++;
            n_fail++;
            $display("FAIL grant_timeout: no grant within 30 cycles (cycle %0d)", cyc);
        end
    endtask

    int g;
    int gl [5];
    int gc [5];
    logic [BW:0]   held_d;
    logic [IW-1:0] held_id;

    initial begin
        rst = 1; req_valid = '0; rsp_ready = 1;
        for (int k = 0; k < N; k++) begin opa[k] = '0; opb[k] = '0; end
        m_clr = 1; m_wait = 0; m_rsp = 0; m_ptr = 0; m_sum = '0; m_id = 0;
        @(negedge clk);
        step(); step();
        rst = 0;

        // Single request from requester 2 while the post-reset clear cycle runs.
        req_valid = 4'b0100; opa[2] = 32'd5; opb[2] = 32'd7;
        step(); chk("post_rst_clr", s_clr, 1); chk("clr_no_ready", s_ready, 0);
        step(); chk("single_ready", s_ready, 4'b0100); chk("single_en", s_en, 1);
        req_valid = '0;
        step(); chk("single_wait_rv", s_rv, 0);
        step(); chk("single_rv", s_rv, 1); chk("single_sum", s_rd, 12); chk("single_id", s_rid, 2);
        step(); chk("clr_between", s_clr, 1);

        // Carry out, with ptr=3 and only requester 0 valid (wrap).
        req_valid = 4'b0001; opa[0] = 32'hFFFF_FFFF; opb[0] = 32'd1;
        wait_grant(g); chk("wrap_grant", g, 0);
        req_valid = '0;
        step(); step();
        chk("carry_sum", s_rd, 33'h1_0000_0000); chk("carry_id", s_rid, 0);
        step();
        req_valid = 4'b0011;
        wait_grant(g); chk("ptr_after_wrap", g, 1);
        req_valid = '0;
        step(); step(); step();

        // Fairness from reset with all requesters held valid.
        rst = 1; step(); rst = 0; step();
        for (int k = 0; k < N; k++) begin opa[k] = rand_op(); opb[k] = rand_op(); end
        req_valid = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            wait_grant(g); gl[i] = g; gc[i] = cyc;
        end
        req_valid = '0;
        for (int i = 0; i < 5; i++) chk("rr_order", 64'(gl[i]), 64'(i % N));
        for (int i = 1; i < 5; i++) chk("rr_spacing", 64'(gc[i] - gc[i-1]), 4);
        step(); step(); step();

        // Back-pressure: response held for 5 cycles with requests pending.
        rsp_ready = 0;
        req_valid = 4'b0100; opa[2] = 32'd100; opb[2] = 32'd23;
        wait_grant(g); chk("bp_grant", g, 2);
        req_valid = 4'b1111;
        step(); step();
        chk("bp_rv", s_rv, 1); chk("bp_data", s_rd, 123); chk("bp_id", s_rid, 2);
        held_d = s_rd; held_id = s_rid;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_hold_rv", s_rv, 1); chk("bp_hold_data", s_rd, held_d);
            chk("bp_hold_id", s_rid, held_id); chk("bp_no_ready", s_ready, 0);
            chk("bp_no_en", s_en, 0);
        end
        rsp_ready = 1;
        step();
        req_valid = '0;
        step(); chk("bp_clr", s_clr, 1);

        // Reset while the result is in flight.
        req_valid = 4'b0100;
        wait_grant(g); chk("mid_grant", g, 2);
        req_valid = '0;
        rst = 1; step();
        chk("mid_rst_clr", s_clr, 1); chk("mid_rst_rv", s_rv, 0);
        chk("mid_rst_en", s_en, 0); chk("mid_rst_ready", s_ready, 0);
        rst = 0;
        step(); chk("mid_no_stale", s_rv, 0);
        req_valid = 4'b1111;
        wait_grant(g); chk("mid_ptr_reset", g, 0);
        req_valid = '0;
        step(); step(); step();

        // Randomized traffic with occasional resets and response back-pressure.
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 299) == 0);
            rsp_ready = ($urandom_range(0, 2) != 0);
            step();
            for (int k = 0; k < N; k++) begin
                if (s_ready[IW'(k)]) req_valid[IW'(k)] = 0;
                if (req_valid[IW'(k)]) begin
                    if ($urandom_range(0, 15) == 0) req_valid[IW'(k)] = 0;
                end else if ($urandom_range(0, 3) == 0) begin
                    req_valid[IW'(k)] = 1;
                    opa[k] = rand_op();
                    opb[k] = rand_op();
                end
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
